// File: rtl/instr_fetch32.sv
// Fetch stage with a FETCH/EXEC handshake: 1+ cycles in FETCH waiting on imem_ready, then EXEC held by stall_in.
// Define FETCH_TIMEOUT_EN to add a HALT state and a sticky fetch_err after TIMEOUT unanswered fetch cycles.
module instr_fetch32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 14
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int          TIMEOUT  = 16
`endif
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ready,
  input  logic [31:0]        Addr_Result,
  input  logic               Zero,
  input  logic [31:0]        Read_data_1,
  input  logic               Branch,
  input  logic               nBranch,
  input  logic               Jmp,
  input  logic               Jal,
  input  logic               Jr,
  input  logic               stall_in,
  output logic [31:0]        Instruction,
  output logic [31:0]        PC_plus_4,
  output logic [31:0]        pc,
  output logic [31:0]        link_addr,
  output logic               inst_valid,
`ifdef FETCH_TIMEOUT_EN
  output logic               fetch_err,
`endif
  output logic [31:0]        instret
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1
`ifdef FETCH_TIMEOUT_EN
    ,
    HALT  = 2'd2
`endif
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] next_pc;
  logic [31:0] jr_target;
  logic        br_taken;

`ifdef FETCH_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT + 1);
  logic [TCW-1:0] tcnt;
  logic           tmo_hit;
  assign tmo_hit = (tcnt == TCW'(TIMEOUT - 1));
`endif

  assign PC_plus_4 = pc + 32'd4;
  assign imem_addr = pc[IMEM_AW+1:2];
  assign jr_target = Read_data_1 & ~32'h0000_0003;
  assign br_taken  = (Branch & Zero) | (nBranch & ~Zero);

  always_comb begin
    next_pc = PC_plus_4;
    if (Jr)
      next_pc = jr_target;
    else if (Jmp | Jal)
      next_pc = {PC_plus_4[31:28], Instruction[25:0], 2'b00};
    else if (br_taken)
      next_pc = Addr_Result;
  end

  always_ff @(posedge clock) begin
    if (reset)
      state <= FETCH;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (imem_ready)
          state_nxt = EXEC;
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_hit)
          state_nxt = HALT;
`endif
      end
      EXEC: begin
        if (!stall_in)
          state_nxt = FETCH;
      end
`ifdef FETCH_TIMEOUT_EN
      HALT:    state_nxt = HALT;
`endif
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    imem_req   = (state == FETCH) & ~reset;
    inst_valid = (state == EXEC);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      Instruction <= '0;
      link_addr   <= '0;
      instret     <= '0;
    end else begin
      if (state == FETCH && imem_ready)
        Instruction <= imem_rdata;
      if (state == EXEC && !stall_in) begin
        pc      <= next_pc;
        instret <= instret + 32'd1;
        if (Jal)
          link_addr <= PC_plus_4;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Counter only runs while a fetch is outstanding, so it is zero on every FETCH entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt      <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state == FETCH && !imem_ready)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;
      if (state == FETCH && !imem_ready && tmo_hit)
        fetch_err <= 1'b1;
    end
  end
`endif

endmodule
